mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Load/store front-end for the data memory of the MIPS MEM stage. Sits directly upstream of
//   the byte-write simple-dual-port BRAM (4x8-bit columns, 1-cycle registered read, read enable).
//   Converts one load/store request per cycle into BRAM byte enables, lane-replicated write
//   data and a read address. Extracts and sign/zero-extends the returned lane one cycle later,
//   and flags misaligned accesses.
// PARAMETERS
//   ADDR_W      9   BRAM word-address width (512 words); byte address is ADDR_W+2 bits
//   BIG_ENDIAN  0   0: byte offset 0 = bits[7:0]; 1: byte offset 0 = bits[31:24]
// PORTS
//   i_clk          in   1         clock, all state on rising edge
//   i_rst          in   1         asynchronous, active-low reset
//   i_valid        in   1         request present this cycle
//   i_wr           in   1         1 = store, 0 = load
//   i_size         in   2         00 byte, 01 half, 10 word, 11 reserved (illegal)
//   i_unsigned     in   1         load zero-extends (lbu/lhu) when 1, sign-extends when 0
//   i_addr         in   ADDR_W+2  byte address
//   i_wdata        in   32        store data, right-justified
//   i_hold         in   1         downstream stall; freezes response stage
//   o_ready        out  1         = ~i_hold; request accepted iff i_valid & o_ready
//   o_bram_waddr   out  ADDR_W    = i_addr[ADDR_W+1:2]
//   o_bram_raddr   out  ADDR_W    = i_addr[ADDR_W+1:2]
//   o_bram_din     out  32        lane-replicated store data
//   o_bram_wen     out  4         byte-write enables
//   o_bram_ren     out  1         BRAM read enable
//   i_bram_dout    in   32        BRAM registered read data
//   o_rdata        out  32        extended load result
//   o_rdata_valid  out  1         o_rdata valid this cycle
//   o_misaligned   out  1         1-cycle pulse, response slot of a faulting request
//   o_badaddr      out  ADDR_W+2  byte address of last faulting request
// BEHAVIOUR
//   Issue (combinational, cycle c): acc = i_valid & ~i_hold. fault = i_size==11 |
//     (i_size==01 & addr[0]) | (i_size==10 & addr[1:0]!=0).
//   Store, acc & ~fault:
//     - sb: din={4{wdata[7:0]}}, wen=one-hot lane(off).
//     - sh: din={2{wdata[15:0]}}, wen=0011/1100 by off[1].
//     - sw: din=wdata, wen=1111.
//     - lane(off) = off (LE) or 3-off (BE); halves map likewise.
//   wen=0 whenever ~acc or fault. ren = acc & ~i_wr & ~fault. A store never asserts ren.
//   Response regs, updated on edge ending cycle c only when ~i_hold:
//     - r_valid <= acc & ~i_wr & ~fault
//     - r_mis   <= acc & fault
//     - r_off, r_size, r_uns <= request fields
//   While i_hold=1: all response regs hold; ren=0 keeps BRAM output stable.
//     o_rdata/o_rdata_valid therefore hold their values across the stall.
//   Cycle c+1 outputs:
//     - o_rdata_valid = r_valid, o_misaligned = r_mis & ~i_hold-edge repeat suppressed.
//       r_mis clears after one un-held cycle.
//     - o_rdata = selected byte/half of i_bram_dout, extended per r_uns, else full word.
//     - o_rdata = 0 when ~r_valid.
//   Load latency: exactly 1 cycle (request cycle c -> data cycle c+1), fully pipelined.
//   Back-to-back store then load to the same word in c, c+1: load returns new data.
//     BRAM write completes at end of c.
//   o_badaddr <= i_addr on acc & fault, else holds.
//   Reset (async, i_rst=0):
//     - r_valid, r_mis, r_off, r_size, r_uns, o_badaddr cleared.
//     - o_rdata_valid=0, o_misaligned=0, o_rdata=0.
//     - wen/ren follow inputs combinationally and are forced 0 while in reset.
//   Reset mid-load: pending response discarded, no o_rdata_valid after release.
//     BRAM contents unaffected.
// TESTING
//   sw 0x11223344 @0x10, lw @0x10 next cycle -> wen=1111, then o_rdata=0x11223344, valid 1 cycle later.
//   sb 0xA5 @0x13 (LE) -> wen=1000, din=0xA5A5A5A5; lb @0x13 -> 0xFFFFFFA5; lbu -> 0x000000A5.
//   sh 0x8001 @0x22, lh @0x22 -> wen=1100; lh -> 0xFFFF8001, lhu -> 0x00008001; BIG_ENDIAN=1 -> wen=0011.
//   lw @0x06 -> wen=0, ren=0, o_misaligned pulse next cycle, o_badaddr=0x06, o_rdata_valid=0; size=11 same.
//   lw issued, i_hold=1 for 3 cycles after -> o_rdata/o_rdata_valid stable 4 cycles, o_ready=0, no new access.
//   lw issued, i_rst low next cycle -> o_rdata_valid=0 immediately and after release; prior BRAM data intact.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front-end for a byte-write BRAM: issues byte enables, replicated store data and
// read address, then extracts and extends the returned lane one cycle later.
module mem_access_unit #(
    parameter int unsigned ADDR_W     = 9,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [ADDR_W+1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_hold,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_bram_waddr,
    output logic [ADDR_W-1:0] o_bram_raddr,
    output logic [31:0]       o_bram_din,
    output logic [3:0]        o_bram_wen,
    output logic              o_bram_ren,
    input  logic [31:0]       i_bram_dout,
    output logic [31:0]       o_rdata,
    output logic              o_rdata_valid,
    output logic              o_misaligned,
    output logic [ADDR_W+1:0] o_badaddr
);

    logic       acc;
    logic       fault;
    logic [1:0] off;
    logic [1:0] lane;
    logic       hi_half;

    assign o_ready      = ~i_hold;
    assign o_bram_waddr = i_addr[ADDR_W+1:2];
    assign o_bram_raddr = i_addr[ADDR_W+1:2];

    always_comb begin
        acc     = i_valid & ~i_hold;
        off     = i_addr[1:0];
        fault   = (i_size == 2'b11) | ((i_size == 2'b01) & off[0]) |
                  ((i_size == 2'b10) & (off != 2'b00));
        lane    = BIG_ENDIAN ? ~off : off;
        hi_half = BIG_ENDIAN ? ~off[1] : off[1];

        case (i_size)
            2'b00:   o_bram_din = {4{i_wdata[7:0]}};
            2'b01:   o_bram_din = {2{i_wdata[15:0]}};
            default: o_bram_din = i_wdata;
        endcase

        // Enables are gated by reset so nothing reaches the BRAM while i_rst is low.
        o_bram_wen = 4'b0000;
        if (i_rst && acc && i_wr && !fault) begin
            case (i_size)
                2'b00:   o_bram_wen = 4'b0001 << lane;
                2'b01:   o_bram_wen = hi_half ? 4'b1100 : 4'b0011;
                default: o_bram_wen = 4'b1111;
            endcase
        end
        o_bram_ren = i_rst & acc & ~i_wr & ~fault;
    end

    logic              r_valid_q, r_valid_d;
    logic              r_mis_q, r_mis_d;
    logic              mis_shown_q, mis_shown_d;
    logic              r_uns_q, r_uns_d;
    logic [1:0]        r_off_q, r_off_d;
    logic [1:0]        r_size_q, r_size_d;
    logic [ADDR_W+1:0] badaddr_q, badaddr_d;

    always_comb begin
        r_valid_d = r_valid_q;
        r_mis_d   = r_mis_q;
        r_uns_d   = r_uns_q;
        r_off_d   = r_off_q;
        r_size_d  = r_size_q;
        badaddr_d = badaddr_q;
        // A fault held across a stall is reported only on its first response cycle.
        mis_shown_d = i_hold ? (mis_shown_q | r_mis_q) : 1'b0;
        if (!i_hold) begin
            r_valid_d = acc & ~i_wr & ~fault;
            r_mis_d   = acc & fault;
            r_uns_d   = i_unsigned;
            r_off_d   = off;
            r_size_d  = i_size;
        end
        if (acc && fault) begin
            badaddr_d = i_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid_q   <= 1'b0;
            r_mis_q     <= 1'b0;
            mis_shown_q <= 1'b0;
            r_uns_q     <= 1'b0;
            r_off_q     <= 2'b00;
            r_size_q    <= 2'b00;
            badaddr_q   <= '0;
        end else begin
            r_valid_q   <= r_valid_d;
            r_mis_q     <= r_mis_d;
            mis_shown_q <= mis_shown_d;
            r_uns_q     <= r_uns_d;
            r_off_q     <= r_off_d;
            r_size_q    <= r_size_d;
            badaddr_q   <= badaddr_d;
        end
    end

    logic [1:0]  rd_lane;
    logic        rd_hi;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_lane = BIG_ENDIAN ? ~r_off_q : r_off_q;
        rd_hi   = BIG_ENDIAN ? ~r_off_q[1] : r_off_q[1];
        rd_byte = i_bram_dout[{rd_lane, 3'b000} +: 8];
        rd_half = i_bram_dout[{rd_hi, 4'b0000} +: 16];
        o_rdata = 32'h0;
        if (r_valid_q) begin
            case (r_size_q)
                2'b00:   o_rdata = r_uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                2'b01:   o_rdata = r_uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                default: o_rdata = i_bram_dout;
            endcase
        end
    end

    assign o_rdata_valid = r_valid_q;
    assign o_misaligned  = r_mis_q & ~mis_shown_q;
    assign o_badaddr     = badaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: BRAM model plus a byte-addressed golden memory predicting
// every enable, store lane and load result.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, wr, uns, hold;
    logic [1:0]  size;
    logic [10:0] addr;
    logic [31:0] wdata;

    logic        ready, ren, rdata_valid, misaligned;
    logic [8:0]  waddr, raddr;
    logic [31:0] din, rdata;
    logic [3:0]  wen;
    logic [10:0] badaddr;
    logic [31:0] bram_dout;

    logic        be_ready, be_ren, be_rdata_valid, be_misaligned;
    logic [8:0]  be_waddr, be_raddr;
    logic [31:0] be_din, be_rdata;
    logic [3:0]  be_wen;
    logic [10:0] be_badaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(9), .BIG_ENDIAN(1'b0)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_wr(wr), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .i_hold(hold), .o_ready(ready),
        .o_bram_waddr(waddr), .o_bram_raddr(raddr), .o_bram_din(din), .o_bram_wen(wen),
        .o_bram_ren(ren), .i_bram_dout(bram_dout), .o_rdata(rdata),
        .o_rdata_valid(rdata_valid), .o_misaligned(misaligned), .o_badaddr(badaddr)
    );

    mem_access_unit #(.ADDR_W(9), .BIG_ENDIAN(1'b1)) u_dut_be (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_wr(wr), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .i_hold(hold), .o_ready(be_ready),
        .o_bram_waddr(be_waddr), .o_bram_raddr(be_raddr), .o_bram_din(be_din),
        .o_bram_wen(be_wen), .o_bram_ren(be_ren), .i_bram_dout(bram_dout), .o_rdata(be_rdata),
        .o_rdata_valid(be_rdata_valid), .o_misaligned(be_misaligned), .o_badaddr(be_badaddr)
    );

    // Byte-write BRAM with registered read, driven by the little-endian instance only.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (ren) bram_dout <= mem[raddr];
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
        end
    end

    // Reference model state
    logic [7:0]  gmem [2048];
    logic        m_valid = 1'b0, m_mis = 1'b0, m_shown = 1'b0;
    logic [31:0] m_data = 32'h0;
    logic [10:0] m_bad = 11'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic u,
                        input logic [10:0] a, input logic [31:0] d, input logic h);
        int          n;
        logic        acc, flt;
        logic [3:0]  e_wen;
        logic [31:0] e_din, lv;
        logic [10:0] ba;
        @(negedge clk);
        valid = v; wr = w; size = sz; uns = u; addr = a; wdata = d; hold = h;
        #1;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        acc = v && !h;
        flt = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        e_wen = 4'b0;
        e_din = 32'h0;
        if (acc && !flt && w) begin
            for (int i = 0; i < n; i++) begin
                ba = a + 11'(i);
                e_wen[ba[1:0]] = 1'b1;
            end
            for (int l = 0; l < 4; l++) e_din[8*l +: 8] = d[8*(l % n) +: 8];
            chk("din", din, e_din);
        end
        chk("wen", {28'h0, wen}, {28'h0, e_wen});
        chk("ren", {31'h0, ren}, {31'h0, acc && !w && !flt});
        chk("ready", {31'h0, ready}, {31'h0, !h});
        chk("raddr", {23'h0, raddr}, {23'h0, a[10:2]});
        chk("waddr", {23'h0, waddr}, {23'h0, a[10:2]});
        chk("rdata_valid", {31'h0, rdata_valid}, {31'h0, m_valid});
        chk("rdata", rdata, m_valid ? m_data : 32'h0);
        chk("misaligned", {31'h0, misaligned}, {31'h0, m_mis && !m_shown});
        chk("badaddr", {21'h0, badaddr}, {21'h0, m_bad});
        lv = 32'h0;
        if (!flt) begin
            for (int i = 0; i < n; i++) begin
                ba = a + 11'(i);
                lv[8*i +: 8] = gmem[ba];
            end
            if (!u && n == 1 && lv[7])  lv[31:8]  = 24'hFFFFFF;
            if (!u && n == 2 && lv[15]) lv[31:16] = 16'hFFFF;
        end
        m_shown = h ? (m_shown || m_mis) : 1'b0;
        if (!h) begin
            m_valid = acc && !w && !flt;
            m_mis   = acc && flt;
            m_data  = lv;
        end
        if (acc && flt) m_bad = a;
        if (acc && !flt && w) begin
            for (int i = 0; i < n; i++) begin
                ba = a + 11'(i);
                gmem[ba] = d[8*i +: 8];
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 1'b0, 11'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [1:0]  rs;
        logic [10:0] ra;
        rst_n = 1'b0;
        valid = 1'b1; wr = 1'b1; size = 2'd2; uns = 1'b0; addr = 11'h10;
        wdata = 32'hCAFEF00D; hold = 1'b0;
        #1;
        chk("rst_wen", {28'h0, wen}, 32'h0);
        chk("rst_ren", {31'h0, ren}, 32'h0);
        chk("rst_rdata_valid", {31'h0, rdata_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("rst_badaddr", {21'h0, badaddr}, 32'h0);
        repeat (2) @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++) step(1'b1, 1'b1, 2'd2, 1'b0, 11'(i * 4), $urandom, 1'b0);

        step(1'b1, 1'b1, 2'd2, 1'b0, 11'h10, 32'h11223344, 1'b0);
        chk("sw_wen", {28'h0, wen}, 32'hF);
        step(1'b1, 1'b0, 2'd2, 1'b0, 11'h10, 32'h0, 1'b0);
        idle();
        chk("lw_result", rdata, 32'h11223344);

        step(1'b1, 1'b1, 2'd0, 1'b0, 11'h13, 32'h000000A5, 1'b0);
        chk("sb_din", din, 32'hA5A5A5A5);
        chk("sb_be_wen", {28'h0, be_wen}, 32'h1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 11'h13, 32'h0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b1, 11'h13, 32'h0, 1'b0);
        chk("lb_result", rdata, 32'hFFFFFFA5);
        idle();
        chk("lbu_result", rdata, 32'h000000A5);

        step(1'b1, 1'b1, 2'd1, 1'b0, 11'h22, 32'h00008001, 1'b0);
        chk("sh_wen", {28'h0, wen}, 32'hC);
        chk("sh_be_wen", {28'h0, be_wen}, 32'h3);
        step(1'b1, 1'b0, 2'd1, 1'b0, 11'h22, 32'h0, 1'b0);
        step(1'b1, 1'b0, 2'd1, 1'b1, 11'h22, 32'h0, 1'b0);
        chk("lh_result", rdata, 32'hFFFF8001);
        idle();
        chk("lhu_result", rdata, 32'h00008001);

        step(1'b1, 1'b0, 2'd2, 1'b0, 11'h06, 32'h0, 1'b0);
        step(1'b1, 1'b0, 2'd3, 1'b0, 11'h20, 32'h0, 1'b0);
        chk("mis_pulse", {31'h0, misaligned}, 32'h1);
        chk("mis_badaddr", {21'h0, badaddr}, 32'h06);
        idle();
        chk("mis_rsv_badaddr", {21'h0, badaddr}, 32'h20);
        idle();

        step(1'b1, 1'b0, 2'd2, 1'b0, 11'h10, 32'h0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 2'd2, 1'b0, 11'h20, 32'h0, 1'b1);
        idle();
        step(1'b1, 1'b0, 2'd2, 1'b0, 11'h05, 32'h0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 11'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 11'h0, 32'h0, 1'b1);
        idle();

        step(1'b1, 1'b0, 2'd2, 1'b0, 11'h10, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b1; wr = 1'b1; size = 2'd2; addr = 11'h10; wdata = 32'hDEADBEEF; hold = 1'b0;
        #1;
        chk("midrst_rdata_valid", {31'h0, rdata_valid}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_wen", {28'h0, wen}, 32'h0);
        chk("midrst_ren", {31'h0, ren}, 32'h0);
        m_valid = 1'b0; m_mis = 1'b0; m_shown = 1'b0; m_bad = 11'h0;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        idle();
        step(1'b1, 1'b0, 2'd2, 1'b0, 11'h10, 32'h0, 1'b0);
        idle();
        chk("post_rst_data", rdata, 32'hA5223344);

        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = 11'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'd1) ra[0] = 1'b0;
                if (rs == 2'd2) ra[1:0] = 2'b00;
            end
            step($urandom_range(0, 3) != 0, 1'($urandom), rs, 1'($urandom), ra, $urandom,
                 $urandom_range(0, 4) == 0);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
